// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues one instruction-memory read at a time,
// advances the upstream PC register via PCEn when a read is accepted,
// and buffers returned words with their fetch address in a two-entry FIFO
// for decode. Handles redirect flushes and traps on misaligned PCs.
module instr_fetch_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  output logic        PCEn,
  output logic [31:0] PCPlus4,
  input  logic        Flush,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemGnt,
  input  logic        IMemRValid,
  input  logic [31:0] IMemRData,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  input  logic        InstrReady,
  output logic        MisalignFault
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

  state_t      state_q, state_d;
  logic [31:0] reqPc_q, reqPc_d;
  logic [1:0]  count_q, count_d;
  logic [63:0] entry_q [2];
  logic [63:0] entry_d [2];

  logic        aligned;
  logic        reqRaw;
  logic        grantRaw;
  logic        push;
  logic        pop;
  logic [63:0] newEntry;

  assign aligned    = (PC[1:0] == 2'b00);
  assign PCPlus4    = PC + 32'd4;
  assign IMemAddr   = PC;
  assign InstrValid = (count_q != 2'd0);
  assign InstrPC    = entry_q[0][63:32];
  assign Instr      = entry_q[0][31:0];
  assign MisalignFault = (state_q == S_FAULT);
  assign newEntry   = {reqPc_q, IMemRData};
  assign pop        = InstrValid && InstrReady && !Flush;
  assign grantRaw   = reqRaw && IMemGnt;

  // Next-state and request logic; request gating only looks at registered
  // count so decode readiness never reaches the memory request path.
  always_comb begin
    state_d = state_q;
    reqPc_d = reqPc_q;
    reqRaw  = 1'b0;
    push    = 1'b0;
    case (state_q)
      S_REQ: begin
        reqRaw = !Flush && (count_q < FULL_COUNT) && aligned;
        if (Flush) begin
          state_d = S_REQ;
        end else if (!aligned) begin
          state_d = S_FAULT;
        end else if (grantRaw) begin
          reqPc_d = PC;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (Flush) begin
          state_d = IMemRValid ? S_REQ : S_DRAIN;
        end else if (IMemRValid) begin
          push   = 1'b1;
          reqRaw = (count_q == 2'd0) && aligned;
          if (grantRaw) begin
            reqPc_d = PC;
            state_d = S_WAIT;
          end else if (!aligned) begin
            state_d = S_FAULT;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_DRAIN: begin
        if (IMemRValid) begin
          state_d = S_REQ;
        end
      end
      S_FAULT: begin
        if (Flush) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
    IMemReq = reqRaw && !rst;
    PCEn    = grantRaw && !rst;
  end

  // FIFO update: entry 0 is always the head, so a pop shifts entry 1 down.
  always_comb begin
    count_d    = count_q;
    entry_d[0] = entry_q[0];
    entry_d[1] = entry_q[1];
    if (Flush) begin
      count_d = 2'd0;
    end else if (pop && push) begin
      if (count_q == 2'd1) begin
        entry_d[0] = newEntry;
      end else begin
        entry_d[0] = entry_q[1];
        entry_d[1] = newEntry;
      end
    end else if (pop) begin
      entry_d[0] = entry_q[1];
      count_d    = count_q - 2'd1;
    end else if (push && (count_q < FULL_COUNT)) begin
      entry_d[count_q[0]] = newEntry;
      count_d             = count_q + 2'd1;
    end
  end

  // State registers with synchronous reset; an in-flight response is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      reqPc_q    <= 32'd0;
      count_q    <= 2'd0;
      entry_q[0] <= 64'd0;
      entry_q[1] <= 64'd0;
    end else begin
      state_q    <= state_d;
      reqPc_q    <= reqPc_d;
      count_q    <= count_d;
      entry_q[0] <= entry_d[0];
      entry_q[1] <= entry_d[1];
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: models the upstream PC register
// and a fixed-latency instruction memory whose word equals its address.
// Expected fetches are queued by the stimulus; a monitor compares each pop.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] PC;
  logic        PCEn;
  logic [31:0] PCPlus4;
  logic        Flush = 1'b0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemGnt;
  logic        IMemRValid = 1'b0;
  logic [31:0] IMemRData = 32'd0;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic        InstrReady = 1'b0;
  logic        MisalignFault;

  logic [31:0] pcReg = 32'd0;
  logic [31:0] flushTarget = 32'd0;
  int          memDelay = 1;
  logic        memBusy = 1'b0;
  logic [31:0] memAddr = 32'd0;
  int          memCnt = 0;
  logic        memNv;
  logic [31:0] memNd;

  int          compared = 0;
  int          mismatched = 0;
  int          popCount = 0;
  int          cyc = 0;
  logic [63:0] expQ[$];
  int          popCycles[$];

  instr_fetch_unit #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .PC(PC), .PCEn(PCEn), .PCPlus4(PCPlus4),
    .Flush(Flush), .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemGnt(IMemGnt),
    .IMemRValid(IMemRValid), .IMemRData(IMemRData), .InstrValid(InstrValid),
    .Instr(Instr), .InstrPC(InstrPC), .InstrReady(InstrReady),
    .MisalignFault(MisalignFault)
  );

  always #5 clk = ~clk;

  assign PC      = pcReg;
  assign IMemGnt = IMemReq;

  // Upstream PC register: reset to 0, redirect on Flush, else advance on PCEn.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst)        pcReg <= 32'd0;
    else if (Flush) pcReg <= flushTarget;
    else if (PCEn)  pcReg <= pcReg + 32'd4;
  end

  // Memory response selection for the coming cycle.
  always_comb begin
    memNv = 1'b0;
    memNd = 32'hDEAD_BEEF;
    if (memBusy && memCnt == 1) begin
      memNv = 1'b1;
      memNd = memAddr;
    end
    if (IMemReq && IMemGnt && memDelay == 1) begin
      memNv = 1'b1;
      memNd = IMemAddr;
    end
  end

  // Memory model: grant same cycle, data memDelay cycles after the grant.
  always @(posedge clk) begin
    IMemRValid <= memNv;
    IMemRData  <= memNd;
    if (memBusy) begin
      if (memCnt == 1) memBusy <= 1'b0;
      else             memCnt  <= memCnt - 1;
    end
    if (IMemReq && IMemGnt && memDelay > 1) begin
      memBusy <= 1'b1;
      memAddr <= IMemAddr;
      memCnt  <= memDelay - 1;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: protocol invariants each cycle and scoreboard compare on each pop.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("PCEnEqualsGrant", {63'd0, PCEn}, {63'd0, IMemReq & IMemGnt});
      if (IMemReq) checkOutput("IMemAddrEqualsPC", {32'd0, IMemAddr}, {32'd0, PC});
      if (IMemReq && IMemGnt) checkOutput("singleOutstanding", {63'd0, memBusy}, 64'd0);
      if (InstrValid && InstrReady && !Flush) begin
        popCount++;
        popCycles.push_back(cyc);
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpectedPop: got InstrPC=%h Instr=%h, required no output",
                   InstrPC, Instr);
        end else begin
          checkOutput("instrPop", {InstrPC, Instr}, expQ.pop_front());
        end
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ready, input logic flush, input logic [31:0] target);
    InstrReady  = ready;
    Flush       = flush;
    flushTarget = target;
  endtask

  task automatic expectRange(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      expQ.push_back({base + 32'(4 * i), base + 32'(4 * i)});
    end
  endtask

  task automatic doReset(input int n);
    rst = 1'b1;
    repeat (n) nextCycle();
    rst = 1'b0;
  endtask

  task automatic waitPops(input int target, input int budget);
    int n = 0;
    while (popCount < target && n < budget) begin
      nextCycle();
      n++;
    end
    checkOutput("popsReached", {63'd0, popCount >= target}, 64'd1);
  endtask

  task automatic waitGrant(input logic [31:0] addr, input logic anyAddr, input int budget);
    int n = 0;
    logic seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      if (IMemReq && IMemGnt && (anyAddr || IMemAddr == addr)) seen = 1'b1;
      n++;
      nextCycle();
    end
    checkOutput("grantSeen", {63'd0, seen}, 64'd1);
  endtask

  // Directed scenarios; each begins at the start of a cycle (#1 after posedge).
  initial begin
    int base;
    int diff;
    applyStimulus(1'b0, 1'b0, 32'd0);
    memDelay = 1;
    rst = 1'b1;
    repeat (3) nextCycle();
    @(negedge clk);
    checkOutput("rstIMemReq", {63'd0, IMemReq}, 64'd0);
    checkOutput("rstPCEn", {63'd0, PCEn}, 64'd0);
    checkOutput("rstInstrValid", {63'd0, InstrValid}, 64'd0);
    checkOutput("rstMisalign", {63'd0, MisalignFault}, 64'd0);
    nextCycle();
    rst = 1'b0;

    // Zero-wait memory, decode stalled: two entries buffered then hold.
    @(negedge clk);
    checkOutput("c1IMemReq", {63'd0, IMemReq}, 64'd1);
    checkOutput("c1IMemAddr", {32'd0, IMemAddr}, 64'h0);
    checkOutput("c1PCPlus4", {32'd0, PCPlus4}, 64'h4);
    checkOutput("c1InstrValid", {63'd0, InstrValid}, 64'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("c2InstrValid", {63'd0, InstrValid}, 64'd0);
    checkOutput("c2BackToBackReq", {32'd0, IMemReq, 31'd0, IMemAddr == 32'h4}, {32'd1, 32'd1});
    nextCycle();
    @(negedge clk);
    checkOutput("c3InstrValid", {63'd0, InstrValid}, 64'd1);
    checkOutput("c3HeadPC", {32'd0, InstrPC}, 64'h0);
    repeat (8) nextCycle();
    @(negedge clk);
    checkOutput("stallHead", {InstrPC, Instr}, 64'h0);
    checkOutput("stallIMemReq", {63'd0, IMemReq}, 64'd0);
    checkOutput("stallPCHolds", {32'd0, pcReg}, 64'h8);
    nextCycle();
    expectRange(32'h0, 16);
    applyStimulus(1'b1, 1'b0, 32'd0);
    waitPops(popCount + 16, 200);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("streamDrained", 64'(expQ.size()), 64'd0);

    // Three wait states: one instruction every four cycles.
    memDelay = 4;
    doReset(3);
    base = popCount;
    expectRange(32'h0, 8);
    applyStimulus(1'b1, 1'b0, 32'd0);
    waitPops(base + 8, 100);
    applyStimulus(1'b0, 1'b0, 32'd0);
    for (int i = base + 1; i < base + 8; i++) begin
      diff = (i < popCycles.size()) ? popCycles[i] - popCycles[i-1] : -1;
      checkOutput("latencyInterval", 64'(diff), 64'd4);
    end

    // Flush while waiting on 0x8 with 0x4 buffered; redirect to 0x100.
    memDelay = 3;
    doReset(3);
    expectRange(32'h0, 1);
    applyStimulus(1'b1, 1'b0, 32'd0);
    waitPops(popCount + 1, 30);
    applyStimulus(1'b0, 1'b0, 32'd0);
    waitGrant(32'h8, 1'b0, 20);
    applyStimulus(1'b0, 1'b1, 32'h100);
    @(negedge clk);
    checkOutput("flushNoReq", {63'd0, IMemReq}, 64'd0);
    checkOutput("flushNoPCEn", {63'd0, PCEn}, 64'd0);
    checkOutput("preFlushHead", {32'd0, InstrPC}, 64'h4);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("postFlushEmpty", {63'd0, InstrValid}, 64'd0);
    checkOutput("drainNoReq", {63'd0, IMemReq}, 64'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("drainStaleNoReq", {63'd0, IMemReq}, 64'd0);
    nextCycle();
    expectRange(32'h100, 4);
    applyStimulus(1'b1, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("redirectReq", {31'd0, IMemReq, IMemAddr}, {31'd0, 1'b1, 32'h100});
    nextCycle();
    waitPops(popCount + 4, 60);
    applyStimulus(1'b0, 1'b0, 32'd0);

    // Misaligned redirect traps; a flush to 0x200 recovers.
    repeat (12) nextCycle();
    applyStimulus(1'b0, 1'b1, 32'h102);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("misalignNoReq", {63'd0, IMemReq}, 64'd0);
    checkOutput("misalignNotYet", {63'd0, MisalignFault}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      @(negedge clk);
      checkOutput("faultSticky", {62'd0, MisalignFault, IMemReq}, 64'b10);
      checkOutput("faultEmpty", {63'd0, InstrValid}, 64'd0);
    end
    nextCycle();
    applyStimulus(1'b0, 1'b1, 32'h200);
    @(negedge clk);
    checkOutput("faultDuringFlush", {63'd0, MisalignFault}, 64'd1);
    nextCycle();
    expectRange(32'h200, 2);
    applyStimulus(1'b1, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("faultCleared", {63'd0, MisalignFault}, 64'd0);
    checkOutput("resumeReq", {31'd0, IMemReq, IMemAddr}, {31'd0, 1'b1, 32'h200});
    nextCycle();
    waitPops(popCount + 2, 40);
    applyStimulus(1'b0, 1'b0, 32'd0);

    // Reset while a read is in flight; the late response lands during reset.
    waitGrant(32'h0, 1'b1, 20);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstGatesReq", {62'd0, IMemReq, PCEn}, 64'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("midRstEmpty", {63'd0, InstrValid}, 64'd0);
    nextCycle();
    nextCycle();
    rst = 1'b0;
    expectRange(32'h0, 3);
    applyStimulus(1'b1, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("restartReq", {31'd0, IMemReq, IMemAddr}, {31'd0, 1'b1, 32'h0});
    checkOutput("restartEmpty", {63'd0, InstrValid}, 64'd0);
    nextCycle();
    waitPops(popCount + 3, 40);
    applyStimulus(1'b0, 1'b0, 32'd0);

    // PC+4 wraps at the top of the address space.
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("pcPlus4Wrap", {32'd0, PCPlus4}, 64'h0);
    repeat (6) nextCycle();
    checkOutput("finalQueueEmpty", 64'(expQ.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
